shift_load_controller: RTL and testbench

Sequencer for the team's serial-in shift register. It accepts a parallel word over a valid/ready handshake and drives the register's `sin`/`shift_en` inputs for exactly WIDTH cycles. It then captures the register's parallel output `q` and reports completion with a one-cycle `done` pulse. It sits between a parallel producer (switches, UART byte, test logic) and a ShiftRegister instance of matching width.

---
 rtl/shift_ctrl_pkg.sv | 17 +
 rtl/shift_load_controller.sv | 93 +++++++++
 tb/tb_shift_load_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift-register load sequencer: FSM state encoding and
// the width helper for the shifted-bit counter.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE
  } shift_state_t;

  // Counter must reach WIDTH-1 without wrapping; one spare value keeps the
  // width formula simple.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_load_controller.sv
// Serializes a parallel word into a shift register, then captures its q; done
// WIDTH+1 edges after accept, start_ready low (no new word) while busy.
module shift_load_controller
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             abort,
  output logic             sin,
  output logic             shift_en,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  shift_state_t   state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             done_q, done_d;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!abort && start_valid) begin
          hold_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // Move the next bit to be sent onto the output end of hold.
          if (MSB_FIRST != 0) hold_d = {hold_q[WIDTH-2:0], 1'b0};
          else                hold_d = {1'b0, hold_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
        if (!abort) begin
          data_out_d = q_in;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  // Moore outputs only: nothing here depends on an input port.
  assign shift_en    = (state_q == SHIFT);
  assign sin         = shift_en & ((MSB_FIRST != 0) ? hold_q[WIDTH-1] : hold_q[0]);
  assign start_ready = (state_q == IDLE);
  assign busy        = ~start_ready;
  assign data_out    = data_out_q;
  assign done        = done_q;

endmodule

// File: tb/tb_shift_load_controller.sv
// Directed bench for shift_load_controller with behavioural shift registers
// (sin shifted into q[0]) feeding q_in of an MSB-first and an LSB-first instance.
module tb_shift_load_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid;
  logic [4:0] din;
  logic       abort;

  logic       start_ready, sin, shift_en, done, busy;
  logic [4:0] data_out, q_reg;
  logic       l_start_ready, l_sin, l_shift_en, l_done, l_busy;
  logic [4:0] l_data_out, l_q_reg;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  shift_load_controller #(.WIDTH(5), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .din(din), .abort(abort), .sin(sin), .shift_en(shift_en), .q_in(q_reg),
    .data_out(data_out), .done(done), .busy(busy)
  );

  shift_load_controller #(.WIDTH(5), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(l_start_ready),
    .din(din), .abort(abort), .sin(l_sin), .shift_en(l_shift_en), .q_in(l_q_reg),
    .data_out(l_data_out), .done(l_done), .busy(l_busy)
  );

  always @(posedge clk) begin
    if (!reset) begin
      q_reg   <= '0;
      l_q_reg <= '0;
    end else begin
      if (shift_en)   q_reg   <= {q_reg[3:0], sin};
      if (l_shift_en) l_q_reg <= {l_q_reg[3:0], l_sin};
    end
  end

  task automatic test_reset();
    reset = 1'b0; start_valid = 1'b0; din = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({start_ready, busy, shift_en, sin, done} !== 5'b10000)
      $display("FAIL reset_ctrl: got rdy/busy/sen/sin/done=%b want 10000", {start_ready, busy, shift_en, sin, done});
    else n_pass++;
    n_checks++; if (data_out !== 5'b00000)
      $display("FAIL reset_data_out: got %b want 00000", data_out);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_msb_transfer();
    logic [4:0] exp_bits;
    exp_bits = 5'b10110;
    start_valid = 1'b1; din = 5'b10110;
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({shift_en, busy, done} !== 3'b110)
        $display("FAIL msb_shift_ctrl[%0d]: got sen/busy/done=%b want 110", i, {shift_en, busy, done});
      else n_pass++;
      n_checks++; if (sin !== exp_bits[4-i])
        $display("FAIL msb_sin[%0d]: got %b want %b", i, sin, exp_bits[4-i]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++; if ({shift_en, busy, done} !== 3'b010)
      $display("FAIL msb_capture: got sen/busy/done=%b want 010", {shift_en, busy, done});
    else n_pass++;
    @(negedge clk);
    n_checks++; if ({done, start_ready} !== 2'b11 || data_out !== 5'b10110)
      $display("FAIL msb_done: got done/rdy=%b data_out=%b want 11 10110", {done, start_ready}, data_out);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || data_out !== 5'b10110)
      $display("FAIL msb_done_width: got done=%b data_out=%b want 0 10110", done, data_out);
    else n_pass++;
  endtask

  task automatic test_lsb_order();
    logic [4:0] exp_seq;
    exp_seq = 5'b01101;  // expected sin order, first bit at position 4
    start_valid = 1'b1; din = 5'b10110;
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (l_shift_en !== 1'b1 || l_sin !== exp_seq[4-i])
        $display("FAIL lsb_sin[%0d]: got sen=%b sin=%b want 1 %b", i, l_shift_en, l_sin, exp_seq[4-i]);
      else n_pass++;
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++; if (l_done !== 1'b1)
      $display("FAIL lsb_done: got %b want 1", l_done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start_valid = 1'b1; din = 5'b11010;
    @(negedge clk);
    din = 5'b00111;  // must be ignored until the next accept
    repeat (5) @(negedge clk);
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || data_out !== 5'b11010 || start_ready !== 1'b1)
      $display("FAIL b2b_first_done: got done=%b data_out=%b rdy=%b want 1 11010 1", done, data_out, start_ready);
    else n_pass++;
    @(negedge clk);
    start_valid = 1'b0;
    n_checks++; if ({busy, shift_en, done, sin} !== 4'b1100)
      $display("FAIL b2b_second_accept: got busy/sen/done/sin=%b want 1100", {busy, shift_en, done, sin});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0)
        $display("FAIL b2b_early_done[%0d]: got %b want 0", i, done);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || data_out !== 5'b00111)
      $display("FAIL b2b_second_done: got done=%b data_out=%b want 1 00111", done, data_out);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    start_valid = 1'b1; din = 5'b11100;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;  // third SHIFT cycle
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if ({shift_en, start_ready, busy, done} !== 4'b0100)
      $display("FAIL abort_idle: got sen/rdy/busy/done=%b want 0100", {shift_en, start_ready, busy, done});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || data_out !== 5'b00111)
        $display("FAIL abort_no_done[%0d]: got done=%b data_out=%b want 0 00111", i, done, data_out);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_bits;
    exp_bits = 5'b11001;
    start_valid = 1'b1; din = 5'b10101;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++; if ({start_ready, busy, shift_en, sin, done} !== 5'b10000 || data_out !== 5'b00000)
      $display("FAIL reset_mid: got rdy/busy/sen/sin/done=%b data_out=%b want 10000 00000",
               {start_ready, busy, shift_en, sin, done}, data_out);
    else n_pass++;
    start_valid = 1'b1; din = 5'b11001;
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (shift_en !== 1'b1 || sin !== exp_bits[4-i])
        $display("FAIL reset_mid_sin[%0d]: got sen=%b sin=%b want 1 %b", i, shift_en, sin, exp_bits[4-i]);
      else n_pass++;
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || data_out !== 5'b11001)
      $display("FAIL reset_mid_done: got done=%b data_out=%b want 1 11001", done, data_out);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort_priority();
    abort = 1'b1; start_valid = 1'b1; din = 5'b11111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if ({busy, start_ready, shift_en} !== 3'b010)
        $display("FAIL abort_prio[%0d]: got busy/rdy/sen=%b want 010", i, {busy, start_ready, shift_en});
      else n_pass++;
    end
    abort = 1'b0; start_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy, done, data_out} !== {2'b00, 5'b11001})
      $display("FAIL abort_prio_after: got busy=%b done=%b data_out=%b want 0 0 11001", busy, done, data_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_msb_transfer();
    test_lsb_order();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_abort_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
